// File: rtl/spram_arbiter.sv
// Two-requester round-robin arbiter with grant locking in front of a single-port RAM.
// Define SPRAM_ARB_STATS_EN to add saturating per-requester grant counters (gnt_cnt0/gnt_cnt1).
module spram_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 64,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          rq_valid,
    output logic [1:0]          rq_ready,
    input  logic [1:0]          rq_wen,
    input  logic [1:0]          rq_lock,
    input  logic [1:0][AW-1:0]  rq_addr,
    input  logic [1:0][DW-1:0]  rq_wdata,
    output logic [1:0]          rs_valid,
    output logic [1:0][DW-1:0]  rs_rdata,
    output logic [AW-1:0]       addr,
    output logic                wen,
    output logic                me,
    output logic [DW-1:0]       wdata,
    input  logic [DW-1:0]       rdata
`ifdef SPRAM_ARB_STATS_EN
    ,
    output logic [31:0]         gnt_cnt0,
    output logic [31:0]         gnt_cnt1
`endif
);

    typedef enum logic {
        ST_ARB,
        ST_LOCKED
    } state_e;

    state_e state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   gnt_idx;
    logic   accept;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_ARB;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // The requester that did not win last has priority when both ask; a lock pins the grant.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_idx = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (rq_valid == 2'b11) begin
                    gnt_idx = ~last_q;
                end else begin
                    gnt_idx = rq_valid[1];
                end
                accept = |rq_valid;
            end
            ST_LOCKED: begin
                gnt_idx = owner_q;
                accept  = rq_valid[owner_q];
            end
            default: begin
                gnt_idx = 1'b0;
                accept  = 1'b0;
            end
        endcase

        if (accept) begin
            if (rq_lock[gnt_idx]) begin
                state_d = ST_LOCKED;
                owner_d = gnt_idx;
            end else begin
                state_d = ST_ARB;
                last_d  = gnt_idx;
            end
        end

        rq_ready = 2'b00;
        if (accept) begin
            rq_ready = gnt_idx ? 2'b10 : 2'b01;
        end
    end

    logic          me_q, wen_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            me_q    <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            me_q  <= accept;
            wen_q <= accept & rq_wen[gnt_idx];
            if (accept) begin
                addr_q  <= rq_addr[gnt_idx];
                wdata_q <= rq_wdata[gnt_idx];
            end
        end
    end

    assign me    = me_q;
    assign wen   = wen_q;
    assign addr  = addr_q;
    assign wdata = wdata_q;

    // Stage k holds the read issued k cycles after the command reached the RAM port.
    logic [RD_LAT:0] tag_vld_q;
    logic [RD_LAT:0] tag_id_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_vld_q <= '0;
            tag_id_q  <= '0;
        end else begin
            tag_vld_q <= {tag_vld_q[RD_LAT-1:0], accept & ~rq_wen[gnt_idx]};
            tag_id_q  <= {tag_id_q[RD_LAT-1:0], gnt_idx};
        end
    end

    logic [1:0]         rs_valid_q, rs_valid_d;
    logic [1:0][DW-1:0] rs_rdata_q;

    always_comb begin
        rs_valid_d = 2'b00;
        if (tag_vld_q[RD_LAT]) begin
            rs_valid_d = tag_id_q[RD_LAT] ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_valid_q <= 2'b00;
            rs_rdata_q <= '0;
        end else begin
            rs_valid_q <= rs_valid_d;
            for (int i = 0; i < 2; i++) begin
                if (rs_valid_d[i]) begin
                    rs_rdata_q[i] <= rdata;
                end
            end
        end
    end

    assign rs_valid = rs_valid_q;
    assign rs_rdata = rs_rdata_q;

`ifdef SPRAM_ARB_STATS_EN
    logic [31:0] gnt_cnt0_q, gnt_cnt1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_cnt0_q <= '0;
            gnt_cnt1_q <= '0;
        end else begin
            if (accept && !gnt_idx && (gnt_cnt0_q != 32'hFFFF_FFFF)) begin
                gnt_cnt0_q <= gnt_cnt0_q + 32'd1;
            end
            if (accept && gnt_idx && (gnt_cnt1_q != 32'hFFFF_FFFF)) begin
                gnt_cnt1_q <= gnt_cnt1_q + 32'd1;
            end
        end
    end

    assign gnt_cnt0 = gnt_cnt0_q;
    assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_spram_arbiter.sv
// Scoreboard bench for spram_arbiter: a spec-level arbiter/memory model predicts grants,
// RAM commands and read responses; a negedge monitor compares the DUT against it.
`timescale 1ns/1ps
module tb_spram_arbiter;
    localparam int AW        = 16;
    localparam int DW        = 64;
    localparam int RD_LAT    = 3;
    localparam int MEM_WORDS = 64;

    logic               clk     = 1'b0;
    logic               reset   = 1'b1;
    logic [1:0]         rqValid = '0;
    logic [1:0]         rqReady;
    logic [1:0]         rqWen   = '0;
    logic [1:0]         rqLock  = '0;
    logic [1:0][AW-1:0] rqAddr  = '0;
    logic [1:0][DW-1:0] rqWdata = '0;
    logic [1:0]         rsValid;
    logic [1:0][DW-1:0] rsRdata;
    logic [AW-1:0]      memAddr;
    logic               memWen;
    logic               memMe;
    logic [DW-1:0]      memWdata;
    logic [DW-1:0]      memRdata;
`ifdef SPRAM_ARB_STATS_EN
    logic [31:0]        gntCnt0;
    logic [31:0]        gntCnt1;
`endif

    int vectors     = 0;
    int miscompares = 0;

    spram_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk      (clk),
        .reset    (reset),
        .rq_valid (rqValid),
        .rq_ready (rqReady),
        .rq_wen   (rqWen),
        .rq_lock  (rqLock),
        .rq_addr  (rqAddr),
        .rq_wdata (rqWdata),
        .rs_valid (rsValid),
        .rs_rdata (rsRdata),
        .addr     (memAddr),
        .wen      (memWen),
        .me       (memMe),
        .wdata    (memWdata),
        .rdata    (memRdata)
`ifdef SPRAM_ARB_STATS_EN
        ,
        .gnt_cnt0 (gntCnt0),
        .gnt_cnt1 (gntCnt1)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] initWord(input logic [5:0] a);
        return {4{10'h000, a}} ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    // Single-port RAM device with RD_LAT cycles of read latency.
    logic [DW-1:0] devMem     [MEM_WORDS];
    bit            devWritten [MEM_WORDS];
    logic [DW-1:0] devPipe    [RD_LAT];

    assign memRdata = devPipe[RD_LAT-1];

    always @(posedge clk) begin
        if (memMe && memWen) begin
            devMem[memAddr[5:0]]     <= memWdata;
            devWritten[memAddr[5:0]] <= 1'b1;
        end
        if (memMe && !memWen) begin
            devPipe[0] <= devWritten[memAddr[5:0]] ? devMem[memAddr[5:0]] : initWord(memAddr[5:0]);
        end
        for (int i = 1; i < RD_LAT; i++) begin
            devPipe[i] <= devPipe[i-1];
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference model state: lock owner (-1 = arbitrating), last grant, memory image, expected responses.
    typedef struct {
        bit            req;
        logic [DW-1:0] data;
        int            due;
    } rsp_t;

    rsp_t               sbq[$];
    int                 cyc       = 0;
    int                 ownerM    = -1;
    bit                 lastM     = 1'b1;
    bit                 pendVld   = 1'b0;
    bit                 pendWen   = 1'b0;
    logic [AW-1:0]      pendAddr  = '0;
    logic [DW-1:0]      pendWdata = '0;
    logic [1:0][DW-1:0] lastData  = '0;
    logic [DW-1:0]      modelMem     [MEM_WORDS];
    bit                 modelWritten [MEM_WORDS];
    int                 acceptCnt    [2];

    function automatic logic [1:0] modelReady(input logic [1:0] v);
        if (ownerM >= 0) return v & (2'b01 << ownerM);
        if (v == 2'b11) return lastM ? 2'b01 : 2'b10;
        return v;
    endfunction

    always @(negedge clk) begin
        logic [1:0]    expReady;
        logic [1:0]    acc;
        int            g;
        rsp_t          e;
        logic [5:0]    idx;
        cyc++;
        if (!reset) begin
            ownerM    = -1;
            lastM     = 1'b1;
            pendVld   = 1'b0;
            lastData  = '0;
            acceptCnt[0] = 0;
            acceptCnt[1] = 0;
            sbq.delete();
            checkOutput("reset_outputs", {rsValid, memMe, memWen, memAddr, memWdata},
                        {2'b00, 1'b0, 1'b0, {AW{1'b0}}, {DW{1'b0}}});
            checkOutput("reset_rdata", rsRdata, '0);
        end else begin
            expReady = modelReady(rqValid);
            checkOutput("rq_ready", rqReady, expReady);

            if (pendVld) begin
                checkOutput("mem_cmd", {memMe, memWen, memAddr, (pendWen ? memWdata : {DW{1'b0}})},
                            {1'b1, pendWen, pendAddr, (pendWen ? pendWdata : {DW{1'b0}})});
            end else begin
                checkOutput("mem_idle", {memMe, memWen}, 2'b00);
            end

            if (rsValid != 2'b00) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_rsp", rsValid, 2'b00);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("rsp_tag", rsValid, 2'b01 << e.req);
                    checkOutput("rsp_cycle", cyc, e.due);
                    checkOutput("rsp_data", rsRdata[e.req], e.data);
                    lastData[e.req] = e.data;
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                checkOutput("rsp_missing", rsValid, 2'b01 << e.req);
            end

            for (int i = 0; i < 2; i++) begin
                if (!rsValid[i]) checkOutput("rsp_hold", rsRdata[i], lastData[i]);
            end

            acc     = rqValid & expReady;
            pendVld = 1'b0;
            if (acc != 2'b00) begin
                g         = acc[1] ? 1 : 0;
                idx       = rqAddr[g][5:0];
                pendVld   = 1'b1;
                pendWen   = rqWen[g];
                pendAddr  = rqAddr[g];
                pendWdata = rqWdata[g];
                acceptCnt[g]++;
                if (rqWen[g]) begin
                    modelMem[idx]     = rqWdata[g];
                    modelWritten[idx] = 1'b1;
                end else begin
                    e.req  = g[0];
                    e.data = modelWritten[idx] ? modelMem[idx] : initWord(idx);
                    e.due  = cyc + 2 + RD_LAT;
                    sbq.push_back(e);
                end
                if (rqLock[g]) begin
                    ownerM = g;
                end else begin
                    ownerM = -1;
                    lastM  = g[0];
                end
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                                 input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                 input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        @(posedge clk);
        #1;
        rqValid    = v;
        rqWen      = w;
        rqLock     = l;
        rqAddr[0]  = a0;
        rqAddr[1]  = a1;
        rqWdata[0] = d0;
        rqWdata[1] = d1;
    endtask

    function automatic logic [AW-1:0] randAddr();
        return AW'($urandom_range(0, MEM_WORDS - 1));
    endfunction

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Both requesters streaming reads: grants alternate 0,1,0,1,...
        for (int n = 0; n < 6; n++) applyStimulus(2'b11, 2'b00, 2'b00, randAddr(), randAddr(), '0, '0);
        applyStimulus(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);

        // Write then read the same word on consecutive cycles.
        applyStimulus(2'b01, 2'b01, 2'b00, 16'h0010, '0, 64'hDEAD_BEEF_0000_0001, '0);
        applyStimulus(2'b01, 2'b00, 2'b00, 16'h0010, '0, '0, '0);
        repeat (RD_LAT + 3) applyStimulus(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);

        // Requester 1 holds the grant for four beats while requester 0 waits.
        for (int n = 0; n < 3; n++) applyStimulus(2'b11, 2'b00, 2'b10, randAddr(), randAddr(), '0, '0);
        applyStimulus(2'b11, 2'b00, 2'b00, randAddr(), randAddr(), '0, '0);
        applyStimulus(2'b11, 2'b00, 2'b00, randAddr(), randAddr(), '0, '0);
        applyStimulus(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);

        // Eight back-to-back reads from alternating requesters.
        for (int n = 0; n < 8; n++) applyStimulus(2'b11, 2'b00, 2'b00, randAddr(), randAddr(), '0, '0);
        repeat (RD_LAT + 3) applyStimulus(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);

        // Reset one cycle after a read is accepted; a command is offered on the first cycle after release.
        applyStimulus(2'b01, 2'b00, 2'b00, 16'h0005, '0, '0, '0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        rqValid = 2'b00;
        #1;
        checkOutput("reset_async_me", memMe, 1'b0);
        checkOutput("reset_async_rsvalid", rsValid, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        reset     = 1'b1;
        rqValid   = 2'b10;
        rqWen     = 2'b00;
        rqLock    = 2'b00;
        rqAddr[1] = 16'h0007;
        repeat (RD_LAT + 4) applyStimulus(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);

        // Randomized traffic with occasional locks.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(2'($urandom()), 2'($urandom()),
                          {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)},
                          randAddr(), randAddr(),
                          {$urandom(), $urandom()}, {$urandom(), $urandom()});
        end
        repeat (RD_LAT + 6) applyStimulus(2'b00, 2'b00, 2'b00, '0, '0, '0, '0);
        @(negedge clk);
        checkOutput("scoreboard_empty", sbq.size(), 0);

`ifdef SPRAM_ARB_STATS_EN
        checkOutput("gnt_cnt0", gntCnt0, acceptCnt[0]);
        checkOutput("gnt_cnt1", gntCnt1, acceptCnt[1]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
